inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_pkg.sv | 58 +++++
 rtl/inst_encoder_if.sv | 29 ++
 rtl/inst_fifo.sv | 52 +++++
 rtl/inst_encoder.sv | 113 +++++++++++
 tb/tb_inst_encoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_pkg.sv
// Shared types, field positions and encoding helpers for the instruction encoder.
package inst_pkg;

   localparam int INST_W     = 26;
   localparam int IMM_W      = 20;
   localparam int FIFO_DEPTH = 4;

   localparam int TYPE_LSB = 24;
   localparam int OP_LSB   = 20;
   localparam int RD_LSB   = 16;
   localparam int RS1_LSB  = 12;
   localparam int RS2_LSB  = 8;

   localparam logic signed [IMM_W-1:0] IMM12_MIN = -20'sd2048;
   localparam logic signed [IMM_W-1:0] IMM12_MAX = 20'sd2047;

   typedef enum logic [1:0] {
      ALU_T = 2'b00,
      MEM_T = 2'b01,
      REG_T = 2'b10,
      BR_T  = 2'b11
   } inst_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } enc_state_e;

   function automatic logic imm12_ok(logic [IMM_W-1:0] imm);
      return ($signed(imm) >= IMM12_MIN) && ($signed(imm) <= IMM12_MAX);
   endfunction

   function automatic logic [INST_W-1:0] encode(inst_type_e t, logic [3:0] op, logic [3:0] rd,
                                                logic [3:0] rs1, logic [3:0] rs2,
                                                logic [IMM_W-1:0] imm);
      logic [INST_W-1:0] w;
      w = '0;
      w[TYPE_LSB +: 2] = t;
      w[OP_LSB +: 4]   = op;
      case (t)
         ALU_T: begin
            w[RD_LSB +: 4]  = rd;
            w[RS1_LSB +: 4] = rs1;
            w[RS2_LSB +: 4] = rs2;
         end
         MEM_T, REG_T: begin
            w[RD_LSB +: 4]  = rd;
            w[RS1_LSB +: 4] = rs1;
            w[11:0]         = imm[11:0];
         end
         default: w[IMM_W-1:0] = imm;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the instruction encoder.
interface inst_encoder_if;
   import inst_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_type;
   logic [3:0]       in_op;
   logic [3:0]       in_rd;
   logic [3:0]       in_rs1;
   logic [3:0]       in_rs2;
   logic [IMM_W-1:0] in_imm;

   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [7:0]        out_addr;

   modport master (
      output in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr
   );

   modport slave (
      input  in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr
   );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO with full/empty flags; pushes when full and pops when empty are ignored.
module inst_fifo #(
   parameter int unsigned Width = 26,
   parameter int unsigned Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_wdata,
   input  logic             i_pop,
   output logic [Width-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == CntW'(Depth));
   assign o_empty = (r_cnt == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
         if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// Packs instruction field bundles into 26-bit words and streams them, with addresses,
// towards instruction memory through a small FIFO.
module inst_encoder
   import inst_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [7:0]   base_addr,
   inst_encoder_if.slave bus,
   output logic [8:0]   count,
   output logic         err_range,
   output logic         done
);

   enc_state_e        r_state;
   enc_state_e        w_state_nxt;
   logic [7:0]        r_addr;
   logic [7:0]        w_addr_nxt;
   logic [8:0]        r_count;
   logic [8:0]        w_count_nxt;
   logic              r_err;
   logic              w_err_nxt;
   inst_type_e        w_type;
   logic              w_imm_ok;
   logic              w_in_hs;
   logic              w_out_hs;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic              w_active;
   logic [INST_W-1:0] w_enc;
   logic [INST_W-1:0] w_head;

   assign w_type   = inst_type_e'(bus.in_type);
   assign w_enc    = encode(w_type, bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
   assign w_imm_ok = (w_type == MEM_T || w_type == REG_T) ? imm12_ok(bus.in_imm) : 1'b1;

   // Full alone gates acceptance, so a same-cycle pop never makes room for a push.
   assign bus.in_ready  = (r_state == RUN) && !w_full;
   assign w_in_hs       = bus.in_valid && bus.in_ready;
   assign w_push        = w_in_hs && w_imm_ok;
   assign w_active      = (r_state == RUN) || (r_state == DRAIN);
   assign bus.out_valid = w_active && !w_empty;
   assign w_out_hs      = bus.out_valid && bus.out_ready;
   assign bus.out_inst  = bus.out_valid ? w_head : '0;
   assign bus.out_addr  = r_addr;
   assign count         = r_count;
   assign err_range     = r_err;

   inst_fifo #(
      .Width(INST_W),
      .Depth(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push),
      .i_wdata(w_enc),
      .i_pop  (w_out_hs),
      .o_rdata(w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_count_nxt = r_count;
      w_err_nxt   = r_err;
      done        = 1'b0;
      if (w_out_hs) begin
         w_addr_nxt = r_addr + 8'd1;
         if (r_count != 9'h1FF) w_count_nxt = r_count + 9'd1;
      end
      if (w_in_hs && !w_imm_ok) w_err_nxt = 1'b1;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_addr_nxt  = base_addr;
               w_count_nxt = '0;
               w_err_nxt   = 1'b0;
            end
         end
         RUN:     if (stop) w_state_nxt = DRAIN;
         DRAIN:   if (w_empty) w_state_nxt = DONE;
         DONE: begin
            w_state_nxt = IDLE;
            done        = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_addr  <= w_addr_nxt;
         r_count <= w_count_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encoding, range drops, backpressure, wrap, drain, reset.
module tb_inst_encoder;
   import inst_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic [7:0] base_addr;
   logic [8:0] count;
   logic       err_range;
   logic       done;
   int         n_checks = 0;
   int         n_errors = 0;

   inst_encoder_if bus ();

   inst_encoder dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .base_addr(base_addr),
      .bus      (bus),
      .count    (count),
      .err_range(err_range),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; stop = 1'b0; base_addr = 8'h00;
      bus.in_valid = 1'b0; bus.in_type = 2'b00; bus.in_op = 4'h0; bus.in_rd = 4'h0;
      bus.in_rs1 = 4'h0; bus.in_rs2 = 4'h0; bus.in_imm = 20'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic do_start(input logic [7:0] b);
      base_addr = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic set_bundle(input logic [1:0] t, input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [19:0] imm);
      bus.in_type = t; bus.in_op = op; bus.in_rd = rd;
      bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
   endtask

   // Holds in_valid until the bundle is taken; returns one phase after the accepting edge.
   task automatic push(input logic [1:0] t, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [19:0] imm);
      logic acc;
      set_bundle(t, op, rd, rs1, rs2, imm);
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         acc = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
         n_checks++; n_errors++;
         $display("FAIL push_timeout in_ready never high for type=%b op=%h", t, op);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.out_ready = 1'b0;
      #2;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_inst, bus.out_addr, count, err_range, done}
          !== 48'h0) begin
         n_errors++;
         $display("FAIL reset_outputs got in_ready=%b out_valid=%b inst=%h addr=%h cnt=%0d err=%b done=%b want all 0",
                  bus.in_ready, bus.out_valid, bus.out_inst, bus.out_addr, count, err_range, done);
      end
      tick();
      rst = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL idle_stop_ignored in_ready got=%b want=0", bus.in_ready);
      end
   endtask

   task automatic test_encode();
      logic [1:0]  vt [3] = '{2'b00, 2'b11, 2'b10};
      logic [3:0]  vop[3] = '{4'h3, 4'h5, 4'h9};
      logic [3:0]  vrd[3] = '{4'h1, 4'hE, 4'h7};
      logic [3:0]  vr1[3] = '{4'h2, 4'hD, 4'h6};
      logic [3:0]  vr2[3] = '{4'h4, 4'hC, 4'hF};
      logic [19:0] vim[3] = '{20'hFFFFF, 20'hABCDE, 20'h00123};
      logic [25:0] vex[3] = '{26'h0312400, 26'h35ABCDE, 26'h2976123};
      do_reset();
      bus.out_ready = 1'b1;
      do_start(8'h10);
      n_checks++;
      if (bus.out_addr !== 8'h10 || count !== 9'd0) begin
         n_errors++;
         $display("FAIL start_load addr=%h cnt=%0d want addr=10 cnt=0", bus.out_addr, count);
      end
      for (int i = 0; i < 3; i++) begin
         push(vt[i], vop[i], vrd[i], vr1[i], vr2[i], vim[i]);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_inst !== vex[i] || bus.out_addr !== 8'(16 + i)) begin
            n_errors++;
            $display("FAIL encode_%0d got valid=%b inst=%h addr=%h want valid=1 inst=%h addr=%h",
                     i, bus.out_valid, bus.out_inst, bus.out_addr, vex[i], 8'(16 + i));
         end
         tick();
         n_checks++;
         if (count !== 9'(i + 1)) begin
            n_errors++; $display("FAIL encode_count_%0d got=%0d want=%0d", i, count, i + 1);
         end
      end
   endtask

   // Continues the run left by test_encode: six words emitted so far at the end.
   task automatic test_range();
      n_checks++;
      if (err_range !== 1'b0) begin
         n_errors++; $display("FAIL range_initial err got=%b want=0", err_range);
      end
      push(2'b01, 4'h1, 4'h2, 4'h3, 4'h0, 20'h00800);
      n_checks++;
      if (bus.out_valid !== 1'b0 || err_range !== 1'b1) begin
         n_errors++;
         $display("FAIL range_2048 got valid=%b err=%b want valid=0 err=1", bus.out_valid, err_range);
      end
      push(2'b01, 4'h1, 4'h2, 4'h3, 4'h0, 20'hFFFFF);
      n_checks++;
      if (bus.out_inst !== 26'h1123FFF) begin
         n_errors++; $display("FAIL range_neg1 got=%h want=1123fff", bus.out_inst);
      end
      tick();
      push(2'b10, 4'h4, 4'h0, 4'h1, 4'h0, 20'hFF7FF);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_errors++; $display("FAIL range_m2049 valid got=%b want=0", bus.out_valid);
      end
      push(2'b10, 4'h4, 4'h0, 4'h1, 4'h0, 20'hFF800);
      n_checks++;
      if (bus.out_inst !== 26'h2401800) begin
         n_errors++; $display("FAIL range_m2048 got=%h want=2401800", bus.out_inst);
      end
      tick();
      push(2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 20'h007FF);
      n_checks++;
      if (bus.out_inst !== 26'h10007FF) begin
         n_errors++; $display("FAIL range_2047 got=%h want=10007ff", bus.out_inst);
      end
      tick();
      n_checks++;
      if (count !== 9'd6 || bus.out_addr !== 8'h16 || err_range !== 1'b1) begin
         n_errors++;
         $display("FAIL range_totals cnt=%0d addr=%h err=%b want cnt=6 addr=16 err=1",
                  count, bus.out_addr, err_range);
      end
   endtask

   task automatic test_backpressure();
      logic [25:0] exp[4] = '{26'h0111100, 26'h0222200, 26'h0333300, 26'h0444400};
      do_reset();
      do_start(8'h40);
      for (int i = 0; i < 4; i++) begin
         push(2'b00, 4'(i + 1), 4'(i + 1), 4'(i + 1), 4'(i + 1), 20'h0);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL bp_full in_ready got=%b want=0", bus.in_ready);
      end
      set_bundle(2'b00, 4'h5, 4'h5, 4'h5, 4'h5, 20'h0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_inst !== exp[0] ||
             bus.out_addr !== 8'h40) begin
            n_errors++;
            $display("FAIL bp_hold_%0d rdy=%b valid=%b inst=%h addr=%h want rdy=0 valid=1 inst=%h addr=40",
                     c, bus.in_ready, bus.out_valid, bus.out_inst, bus.out_addr, exp[0]);
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_inst !== exp[i] || bus.out_addr !== 8'(64 + i)) begin
            n_errors++;
            $display("FAIL bp_drain_%0d valid=%b inst=%h addr=%h want valid=1 inst=%h addr=%h",
                     i, bus.out_valid, bus.out_inst, bus.out_addr, exp[i], 8'(64 + i));
         end
         tick();
      end
      n_checks++;
      if (bus.out_valid !== 1'b0 || count !== 9'd4) begin
         n_errors++;
         $display("FAIL bp_end valid=%b cnt=%0d want valid=0 cnt=4", bus.out_valid, count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp[3] = '{8'hFE, 8'hFF, 8'h00};
      do_reset();
      bus.out_ready = 1'b1;
      do_start(8'hFE);
      for (int i = 0; i < 3; i++) begin
         push(2'b11, 4'(i), 4'h0, 4'h0, 4'h0, 20'(i));
         n_checks++;
         if (bus.out_addr !== exp[i]) begin
            n_errors++; $display("FAIL wrap_%0d addr got=%h want=%h", i, bus.out_addr, exp[i]);
         end
         tick();
      end
      n_checks++;
      if (count !== 9'd3 || bus.out_addr !== 8'h01) begin
         n_errors++;
         $display("FAIL wrap_end cnt=%0d addr=%h want cnt=3 addr=01", count, bus.out_addr);
      end
   endtask

   task automatic test_start_stop();
      do_reset();
      base_addr = 8'h30;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_addr !== 8'h30) begin
         n_errors++;
         $display("FAIL start_wins in_ready=%b addr=%h want in_ready=1 addr=30",
                  bus.in_ready, bus.out_addr);
      end
   endtask

   task automatic test_drain();
      logic [25:0] exp[3] = '{26'h0A11100, 26'h0B22200, 26'h0C33300};
      logic [25:0] want;
      int got;
      int dones;
      do_reset();
      do_start(8'h20);
      push(2'b00, 4'hA, 4'h1, 4'h1, 4'h1, 20'h0);
      push(2'b00, 4'hB, 4'h2, 4'h2, 4'h2, 20'h0);
      push(2'b00, 4'hC, 4'h3, 4'h3, 4'h3, 20'h0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_errors++; $display("FAIL drain_in_ready got=%b want=0", bus.in_ready);
      end
      set_bundle(2'b00, 4'hF, 4'hF, 4'hF, 4'hF, 20'h0);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      got = 0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.out_valid) begin
            want = (got < 3) ? exp[got] : 'x;
            n_checks++;
            if (bus.out_inst !== want) begin
               n_errors++; $display("FAIL drain_word_%0d got=%h want=%h", got, bus.out_inst, want);
            end
            got++;
         end
         if (done) dones++;
         tick();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (got !== 3 || dones !== 1 || count !== 9'd3) begin
         n_errors++;
         $display("FAIL drain_totals words=%0d dones=%0d cnt=%0d want words=3 dones=1 cnt=3",
                  got, dones, count);
      end
      do_start(8'h70);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_addr !== 8'h70) begin
         n_errors++;
         $display("FAIL drain_back_idle in_ready=%b addr=%h want in_ready=1 addr=70",
                  bus.in_ready, bus.out_addr);
      end
   endtask

   task automatic test_reset_mid();
      int leaks;
      do_reset();
      bus.out_ready = 1'b1;
      do_start(8'h50);
      push(2'b00, 4'h1, 4'h1, 4'h1, 4'h1, 20'h0);
      tick();
      bus.out_ready = 1'b0;
      push(2'b00, 4'h2, 4'h2, 4'h2, 4'h2, 20'h0);
      push(2'b00, 4'h3, 4'h3, 4'h3, 4'h3, 20'h0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || count !== 9'd1) begin
         n_errors++;
         $display("FAIL mid_pre valid=%b cnt=%0d want valid=1 cnt=1", bus.out_valid, count);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || count !== 9'd0 || bus.out_addr !== 8'h00 ||
          bus.out_inst !== 26'h0) begin
         n_errors++;
         $display("FAIL mid_reset valid=%b cnt=%0d addr=%h inst=%h want all 0",
                  bus.out_valid, count, bus.out_addr, bus.out_inst);
      end
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      leaks = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.out_valid !== 1'b0) leaks++;
      end
      do_start(8'h60);
      tick();
      if (bus.out_valid !== 1'b0) leaks++;
      n_checks++;
      if (leaks != 0 || count !== 9'd0) begin
         n_errors++;
         $display("FAIL mid_no_output leaks=%0d cnt=%0d want leaks=0 cnt=0", leaks, count);
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_range();
      test_backpressure();
      test_wrap();
      test_start_stop();
      test_drain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
